clock_mode_ctrl: RTL

Parametrised successor to the alarm-clock mode state machine. Sequences CLOCK / SET_TM / SET_AL / stopwatch modes from pre-debounced, single-cycle pushbutton pulses and drives the enables and selects for the time, alarm and stopwatch datapaths. Adds three features:
- N_ALARMS alarm slots, stepped with repeated set_alarm presses.
- Stopwatch lap-hold and clear.
- Optional background stopwatch running, plus an inactivity timeout that returns the set modes to CLOCK.

---
 rtl/clock_pkg.sv | 19 +
 rtl/mode_idle_timer.sv | 28 ++
 rtl/clock_mode_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types and helpers for the alarm-clock mode controller.
package clock_pkg;

  typedef enum logic [2:0] {
    CLOCK   = 3'd0,
    SET_TM  = 3'd1,
    SET_AL  = 3'd2,
    SW_STOP = 3'd3,
    SW_RUN  = 3'd4,
    SW_LAP  = 3'd5
  } clk_mode_t;

  localparam int unsigned MAX_ALARMS = 8;

  function automatic int unsigned alarm_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mode_idle_timer.sv
// Saturating idle counter; expire flags the last idle cycle before auto-return.
module mode_idle_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_TOP  = CW'(TIMEOUT_CYC);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || !run || clr)
      r_cnt <= '0;
    else if (r_cnt != CNT_TOP)
      r_cnt <= r_cnt + 1'b1;
  end

  // Activity in the same cycle suppresses expiry.
  assign expire = run && !clr && (r_cnt == CNT_LAST);

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode sequencer for clock / set-time / set-alarm / stopwatch, with alarm
// slot stepping, lap hold, background stopwatch and set-mode timeout.
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned N_ALARMS    = 2,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter bit          BG_RUN      = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                set_time,
  input  logic                                set_alarm,
  input  logic                                stop_watch,
  input  logic                                strtStp,
  input  logic                                lap,
  input  logic                                adj_act,
  output logic                                enable_time,
  output logic                                enable_sw,
  output logic                                sel_sw,
  output logic                                sel_alarm,
  output logic                                en_time_chng,
  output logic                                en_alarm_chng,
  output logic [alarm_idx_w(N_ALARMS)-1:0]    alarm_idx,
  output logic                                lap_hold,
  output logic                                sw_clr,
  output logic                                timeout,
  output logic [2:0]                          state
);

  localparam int unsigned IDX_W = alarm_idx_w(N_ALARMS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ALARMS - 1);

  clk_mode_t        r_state, w_state_nx;
  logic [IDX_W-1:0] r_idx, w_idx_nx;
  logic             r_sw_running, w_run_nx;
  logic             r_sw_clr, w_clr_nx;
  logic             r_timeout, w_to_nx;
  logic             w_expire;
  logic             w_bg;

  generate
    if (TIMEOUT_CYC > 0) begin : g_timer
      logic w_idle_run, w_idle_clr;
      assign w_idle_run = (r_state == SET_TM) || (r_state == SET_AL);
      assign w_idle_clr = adj_act | set_time | set_alarm | stop_watch;
      mode_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle (
        .clk    (clk),
        .rst    (rst),
        .run    (w_idle_run),
        .clr    (w_idle_clr),
        .expire (w_expire)
      );
    end else begin : g_no_timer
      assign w_expire = 1'b0;
    end
  endgenerate

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_run_nx   = r_sw_running;
    w_clr_nx   = 1'b0;
    w_to_nx    = 1'b0;
    case (r_state)
      CLOCK: begin
        if (set_time)
          w_state_nx = SET_TM;
        else if (set_alarm) begin
          w_state_nx = SET_AL;
          w_idx_nx   = '0;
        end else if (stop_watch)
          w_state_nx = (BG_RUN && r_sw_running) ? SW_RUN : SW_STOP;
      end
      SET_TM: begin
        if (set_time)
          w_state_nx = CLOCK;
        else if (w_expire) begin
          w_state_nx = CLOCK;
          w_to_nx    = 1'b1;
        end
      end
      SET_AL: begin
        if (set_alarm) begin
          if (r_idx == IDX_LAST) begin
            w_state_nx = CLOCK;
            w_idx_nx   = '0;
          end else
            w_idx_nx = r_idx + 1'b1;
        end else if (w_expire) begin
          w_state_nx = CLOCK;
          w_idx_nx   = '0;
          w_to_nx    = 1'b1;
        end
      end
      SW_STOP, SW_RUN, SW_LAP: begin
        if (stop_watch) begin
          w_state_nx = CLOCK;
          if (!BG_RUN) w_run_nx = 1'b0;
        end else if (strtStp) begin
          w_state_nx = (r_state == SW_STOP) ? SW_RUN : SW_STOP;
          w_run_nx   = (r_state == SW_STOP);
        end else if (lap) begin
          if (r_state == SW_STOP)     w_clr_nx   = 1'b1;
          else if (r_state == SW_RUN) w_state_nx = SW_LAP;
          else                        w_state_nx = SW_RUN;
        end
      end
      default: w_state_nx = CLOCK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= CLOCK;
      r_idx        <= '0;
      r_sw_running <= 1'b0;
      r_sw_clr     <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_idx        <= w_idx_nx;
      r_sw_running <= w_run_nx;
      r_sw_clr     <= w_clr_nx;
      r_timeout    <= w_to_nx;
    end
  end

  assign w_bg = BG_RUN & r_sw_running;

  always_comb begin
    enable_time   = 1'b1;
    enable_sw     = w_bg;
    sel_sw        = 1'b0;
    sel_alarm     = 1'b0;
    en_time_chng  = 1'b0;
    en_alarm_chng = 1'b0;
    lap_hold      = 1'b0;
    case (r_state)
      SET_TM: begin
        enable_time  = 1'b0;
        en_time_chng = 1'b1;
      end
      SET_AL: begin
        sel_alarm     = 1'b1;
        en_alarm_chng = 1'b1;
      end
      SW_STOP: begin
        enable_sw = 1'b0;
        sel_sw    = 1'b1;
      end
      SW_RUN: begin
        enable_sw = 1'b1;
        sel_sw    = 1'b1;
      end
      SW_LAP: begin
        enable_sw = 1'b1;
        sel_sw    = 1'b1;
        lap_hold  = 1'b1;
      end
      default: ;
    endcase
  end

  assign alarm_idx = r_idx;
  assign sw_clr    = r_sw_clr;
  assign timeout   = r_timeout;
  assign state     = r_state;

endmodule
